// File: rtl/seq_pkg.sv
// Shared types and defaults for the run sequencer.
package seq_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    localparam logic [31:0] WDOG_LIMIT_DEF = 32'd1_000_000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP_WAIT,
        S_COM_WAIT,
        S_HALT
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Program run control: free run, single step, COM handshake, watchdog.
module run_sequencer
    import seq_pkg::*;
#(
    parameter int          CNT_W      = CNT_W_DEF,
    parameter logic [31:0] WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             step_mode,
    input  logic             step,
    input  logic             clear,
    input  logic             end_flag,
    input  logic             com_flag,
    input  logic             host_ack,
    output logic             start,
    output logic             com_req,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] WDOG_LAST =
        CNT_W'(WDOG_LIMIT - 32'd1);

    state_e state_q, state_d;
    logic   timeout_q, timeout_d;
    logic   step_prev_q, step_prev_d;
    logic   clr_cnt;
    logic   in_run;

    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        step_prev_d = step;
        clr_cnt     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d   = step_mode ? S_STEP_WAIT : S_RUN;
                    timeout_d = 1'b0;
                    clr_cnt   = 1'b1;
                end
            end
            S_RUN: begin
                if (end_flag) begin
                    state_d = S_HALT;
                end else if (com_flag) begin
                    state_d = S_COM_WAIT;
                end else if (instr_count == WDOG_LAST) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else if (step_mode) begin
                    state_d = S_STEP_WAIT;
                end
            end
            // Only a fresh rising step releases; a held pulse does not.
            S_STEP_WAIT: begin
                if (step && !step_prev_q) begin
                    state_d = S_RUN;
                end
            end
            S_COM_WAIT: begin
                if (host_ack) begin
                    state_d = step_mode ? S_STEP_WAIT : S_RUN;
                end
            end
            S_HALT: begin
                if (clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            timeout_q   <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timeout_q   <= timeout_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign in_run      = (state_q == S_RUN);
    assign start       = in_run;
    assign com_req     = (state_q == S_COM_WAIT);
    assign done        = (state_q == S_HALT);
    assign busy        = in_run || com_req ||
                         (state_q == S_STEP_WAIT);
    assign timeout_err = timeout_q;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .en    (busy),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .en    (in_run),
        .count (instr_count)
    );

endmodule

// File: tb/tb_run_sequencer.sv
// Directed plus random checks of run_sequencer against a behavioural model.
module tb_run_sequencer;

    localparam int CW   = 4;
    localparam int WD   = 8;
    localparam int MAXC = (1 << CW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_STEP = 2;
    localparam int P_COM  = 3;
    localparam int P_HALT = 4;

    logic clk = 1'b0;
    logic reset, go, step_mode, step, clear;
    logic end_flag, com_flag, host_ack;
    logic start, com_req, busy, done, timeout_err;
    logic [CW-1:0] cycle_count, instr_count;

    int errors = 0;
    int checks = 0;

    int m_ph, m_cyc, m_ins;
    bit m_to, m_prev;

    int n_start, n_com, n_dbl;
    bit prev_start;

    run_sequencer #(.CNT_W(CW), .WDOG_LIMIT(32'd8)) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .step_mode   (step_mode),
        .step        (step),
        .clear       (clear),
        .end_flag    (end_flag),
        .com_flag    (com_flag),
        .host_ack    (host_ack),
        .start       (start),
        .com_req     (com_req),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE;
        m_cyc = 0;
        m_ins = 0;
        m_to = 1'b0;
        m_prev = 1'b0;
    endtask

    // One clock of the reference, from the run-control rules.
    task automatic model_step();
        int nph;
        nph = m_ph;
        if (m_ph == P_IDLE) begin
            if (go) begin
                nph = step_mode ? P_STEP : P_RUN;
                m_cyc = 0;
                m_ins = 0;
                m_to = 1'b0;
            end
        end else if (m_ph == P_RUN) begin
            if (end_flag) nph = P_HALT;
            else if (com_flag) nph = P_COM;
            else if (m_ins == WD - 1) begin
                nph = P_HALT;
                m_to = 1'b1;
            end else if (step_mode) nph = P_STEP;
            m_ins++;
            m_cyc++;
        end else if (m_ph == P_STEP) begin
            if (step && !m_prev) nph = P_RUN;
            m_cyc++;
        end else if (m_ph == P_COM) begin
            if (host_ack) nph = step_mode ? P_STEP : P_RUN;
            m_cyc++;
        end else if (clear) begin
            nph = P_IDLE;
        end
        m_prev = step;
        m_ph = nph;
    endtask

    task automatic check_outputs(string tag);
        chk({tag, ".start"}, start, m_ph == P_RUN);
        chk({tag, ".com_req"}, com_req, m_ph == P_COM);
        chk({tag, ".busy"}, busy,
            m_ph == P_RUN || m_ph == P_STEP || m_ph == P_COM);
        chk({tag, ".done"}, done, m_ph == P_HALT);
        chk({tag, ".timeout"}, timeout_err, m_to);
        chk({tag, ".cycles"}, cycle_count, sat(m_cyc));
        chk({tag, ".instrs"}, instr_count, sat(m_ins));
    endtask

    task automatic tick(string tag = "cyc");
        @(posedge clk);
        if (reset) model_step();
        #1;
        check_outputs(tag);
        if (start) n_start++;
        if (com_req) n_com++;
        if (start && prev_start) n_dbl++;
        prev_start = start;
    endtask

    task automatic set_in(bit g, bit sm, bit st, bit cl,
                          bit e, bit c, bit a);
        go = g;
        step_mode = sm;
        step = st;
        clear = cl;
        end_flag = e;
        com_flag = c;
        host_ack = a;
    endtask

    task automatic zero_stats();
        n_start = 0;
        n_com = 0;
        n_dbl = 0;
        prev_start = 1'b0;
    endtask

    task automatic apply_reset(string tag);
        reset = 1'b0;
        #2;
        model_reset();
        check_outputs(tag);
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        zero_stats();
        #3;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Idle holds without go, even with flags toggling.
        set_in(0, 0, 1, 1, 1, 1, 1);
        repeat (3) tick("idle");
        set_in(0, 0, 0, 0, 0, 0, 0);

        // Free run, END on fifth RUN cycle.
        zero_stats();
        go = 1'b1;
        tick("free");
        go = 1'b0;
        repeat (4) tick("free");
        end_flag = 1'b1;
        tick("free");
        end_flag = 1'b0;
        chk("free_starts", n_start, 5);
        chk("free_done", done, 1);
        chk("free_instr", instr_count, 5);
        chk("free_cycles", cycle_count, 5);
        go = 1'b1;
        repeat (2) tick("halt_go");
        chk("halt_ignores_go", done, 1);
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick("clear");
        clear = 1'b0;

        // COM exchange on RUN cycle three.
        zero_stats();
        go = 1'b1;
        tick("com");
        go = 1'b0;
        repeat (2) tick("com");
        com_flag = 1'b1;
        tick("com");
        com_flag = 1'b0;
        repeat (3) tick("com");
        host_ack = 1'b1;
        tick("com");
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick("com");
        end_flag = 1'b0;
        chk("com_reqs", n_com, 4);
        chk("com_starts", n_start, 4);
        chk("com_diff", cycle_count - instr_count, 4);
        clear = 1'b1;
        tick("clear");
        clear = 1'b0;

        // Stepping, middle pulse held three cycles.
        zero_stats();
        set_in(1, 1, 0, 0, 0, 0, 0);
        tick("step");
        go = 1'b0;
        repeat (2) tick("step");
        step = 1'b1;
        tick("step");
        step = 1'b0;
        repeat (2) tick("step");
        step = 1'b1;
        repeat (3) tick("step");
        step = 1'b0;
        repeat (2) tick("step");
        step = 1'b1;
        tick("step");
        step = 1'b0;
        repeat (2) tick("step");
        chk("step_starts", n_start, 3);
        chk("step_single", n_dbl, 0);
        chk("step_instr", instr_count, 3);
        apply_reset("arst_step");

        // Watchdog at eight RUN cycles.
        zero_stats();
        go = 1'b1;
        tick("wdog");
        go = 1'b0;
        repeat (8) tick("wdog");
        chk("wdog_starts", n_start, 8);
        chk("wdog_to", timeout_err, 1);
        chk("wdog_instr", instr_count, 8);
        chk("wdog_done", done, 1);
        clear = 1'b1;
        tick("clear");
        clear = 1'b0;
        chk("to_sticky_idle", timeout_err, 1);

        // END and COM together: END wins.
        zero_stats();
        go = 1'b1;
        tick("prio");
        set_in(0, 0, 0, 0, 1, 1, 0);
        repeat (3) tick("prio");
        chk("prio_no_com", n_com, 0);
        chk("prio_done", done, 1);
        chk("prio_to_cleared", timeout_err, 0);
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick("clear");
        clear = 1'b0;

        // Long COM wait saturates cycle_count.
        go = 1'b1;
        tick("sat");
        set_in(0, 0, 0, 0, 0, 1, 0);
        tick("sat");
        com_flag = 1'b0;
        repeat (20) tick("sat");
        chk("sat_cycles", cycle_count, MAXC);
        chk("sat_instr", instr_count, 1);

        // Reset mid-COM, then a clean run.
        #2;
        apply_reset("arst_com");
        chk("arst_com_req", com_req, 0);
        go = 1'b1;
        tick("post");
        go = 1'b0;
        tick("post");
        end_flag = 1'b1;
        tick("post");
        end_flag = 1'b0;
        chk("post_instr", instr_count, 2);
        chk("post_cycles", cycle_count, 2);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            go = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) step_mode = ~step_mode;
            step = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 5) == 0);
            end_flag = ($urandom_range(0, 11) == 0);
            com_flag = ($urandom_range(0, 9) == 0);
            host_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                apply_reset("arst_rand");
            end else begin
                tick("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
